// File: rtl/serial_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_adder: bit-serial LSB-first adder, one full-add cell per clock  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-2:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_ha1_s, w_ha1_c, w_ha2_c, w_s, w_c, w_last;
    logic [WIDTH-2:0] w_acc_nxt;

    // Full-add cell: two half adders whose carries are ORed.
    assign w_ha1_s = r_opa[0] ^ r_opb[0];
    assign w_ha1_c = r_opa[0] & r_opb[0];
    assign w_s     = w_ha1_s ^ r_carry;
    assign w_ha2_c = w_ha1_s & r_carry;
    assign w_c     = w_ha1_c | w_ha2_c;

    assign w_last    = (r_cnt == c_LAST);
    assign w_acc_nxt = (WIDTH-1)'({w_s, r_acc} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_opa   <= a;
                r_opb   <= b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == S_SHIFT) begin
                r_opa   <= r_opa >> 1;
                r_opb   <= r_opb >> 1;
                r_acc   <= w_acc_nxt;
                r_carry <= w_c;
                r_cnt   <= r_cnt + c_CNT_W'(1);
                // The last processed bit completes the result directly.
                if (w_last) begin
                    sum  <= {w_s, r_acc};
                    cout <= w_c;
                end
            end
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serial_adder: directed and random checks against a timeline model  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction timeline: an accepted request is busy for W cycles,
    // then done for one, with {cout,sum} = a+b+cin committed at the done cycle.
    bit           m_act;
    int           m_age;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    logic         m_cout;
    int           m_ops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_age  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act  <= 1'b1;
                m_age  <= 0;
                m_pend <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            end
        end else if (m_age == W) begin
            m_act <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == W) begin
                {m_cout, m_sum} <= m_pend;
                m_ops <= m_ops + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_act && m_age < W);
        check("done", done, m_act && m_age == W);
        check("sum",  sum,  m_sum);
        check("cout", cout, m_cout);
    end

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          input logic [W-1:0] es, input logic ec);
        int n, nbusy;
        bit seen;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; nbusy = 0; seen = 0;
        while (!seen && n <= 20) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
                n++;
            end
        end
        check("op_done_seen", seen, 1);
        check("op_latency", n, W + 1);
        check("op_busy_cycles", nbusy, W);
        check("op_sum", sum, es);
        check("op_cout", cout, ec);
    endtask

    initial begin
        int ndone, prev, cnt;
        m_ops = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

        // Second request while busy must be dropped.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            if (n == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            if (n == 4) start = 1'b0;
            if (done) begin
                ndone++;
                check("ign_sum", sum, 8'h30);
                check("ign_cout", cout, 0);
            end
            @(negedge clk);
        end
        check("ign_done_count", ndone, 1);

        // Asynchronous reset in the middle of an operation.
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        prev = -1; cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                check("held_sum", sum, 8'h00);
                check("held_cout", cout, 1);
                if (prev >= 0) check("held_spacing", n - prev, W + 2);
                prev = n;
            end
        end
        check("held_count", cnt >= 3, 1);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Random traffic, including requests that arrive while busy.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("random_ops_seen", m_ops > 150, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first ripple adder. Computes the sum of two WIDTH-bit operands plus a carry-in, one bit per clock.
- Built around a single full-add cell (two half-adder stages plus OR) and a carry flip-flop.
- Additive counterpart to the team's half-subtractor datapath.
- Serves as the low-area arithmetic unit for the lab datapath; a start/busy/done handshake sequences it.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  single-cycle pulse: sum/cout are newly valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out, held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry FF and bit counter are cleared.
  - Deassertion takes effect at the next rising clk edge.
- States: IDLE, SHIFT, DONE. Encoding is free; no illegal state may persist (default -> IDLE).
- IDLE:
  - start=1 at edge E0: load opA<=a, opB<=b, carry<=cin, cnt<=0, state->SHIFT.
  - start=0: remain in IDLE.
  - Operand values on a/b/cin outside the accepting edge are ignored.
- SHIFT (busy=1), at each edge:
  - s = opA[0] ^ opB[0] ^ carry
  - carry <= (opA[0]&opB[0]) | (carry&(opA[0]^opB[0]))
  - opA, opB shift right by 1; s shifts into the MSB of an internal accumulator (accumulator shifts right).
  - cnt <= cnt+1.
- Completion:
  - On the edge where cnt==WIDTH-1 (the WIDTH-th processing edge, E_WIDTH):
    - sum <= {s, acc[WIDTH-1:1]} (the fully assembled result)
    - cout <= new carry
    - state->DONE
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE unconditionally.
- Latency and throughput:
  - Accepted start at E0 -> done high during the cycle following E_WIDTH.
  - That is WIDTH+1 cycles from start sampling to done.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or in DONE: ignored, no queuing; the in-flight operation is unaffected.
- sum/cout change only on the completion edge, never mid-operation; the previous result stays visible while busy.
- Arithmetic is modulo 2^WIDTH; the overflow bit appears only on cout. {cout,sum} == a+b+cin exactly.
- Reset mid-operation: immediate return to IDLE with all outputs zero; no done pulse; the partial result is discarded.
- The counter is sized ceil(log2(WIDTH)) bits minimum and does not wrap within an operation.

Test Plan:
- WIDTH=8, start with a=0x35, b=0x4A, cin=0 -> busy high for 8 cycles; done pulse 9 cycles after start edge; sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (carry chain fully exercised).
- Start a=0x10, b=0x20. Pulse start again at cycle 3 with a=0xAA, b=0x55 -> second request ignored; result sum=0x30, cout=0; exactly one done pulse.
- Assert rst_n=0 asynchronously at cycle 4 of an operation -> busy, done, sum, cout all 0 immediately. After release, a new start with a=0x01, b=0x01 -> sum=0x02.
- Hold start high continuously with fixed a=0x80, b=0x80 -> operations repeat every 10 cycles (WIDTH+2); each yields sum=0x00, cout=1; done never two cycles wide.
- Randomized 1000 operations at WIDTH=8 and WIDTH=16 against the reference model {cout,sum}=a+b+cin -> zero mismatches. Also check that sum is stable while busy.
